// File: rtl/nios_sys_irq_ctrl.sv
// nios_sys_irq_ctrl: Avalon-MM interrupt aggregator for a small Nios system.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   reset      - asynchronous, active-high reset
//   address    - register word select (0 PENDING, 1 MASK, 2 MODE, 3 ACTIVE, 4 RAW, 5 EVCOUNT)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   irq_in     - asynchronous interrupt source lines (bit 0 = interval timer)
//   readdata   - registered read data, 1-cycle latency, no read strobe
//   irq        - registered aggregate interrupt to the CPU
module nios_sys_irq_ctrl #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync_dly_q;
  logic [NUM_IRQ-1:0] latch_q, latch_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [15:0]        evcount_q, evcount_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

  logic               wr_en;
  logic [NUM_IRQ-1:0] wr_bits;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] active;
  logic [2:0]         act_id;
  logic [15:0]        pending_ext, mask_ext, mode_ext, sync_ext;

  always_comb begin
    wr_en   = chipselect & ~write_n;
    wr_bits = writedata[NUM_IRQ-1:0];
    rise    = sync2_q & ~sync_dly_q;
    // Edge-mode lines report the latch, level-mode lines the synchronized input.
    pending = (mode_q & latch_q) | (~mode_q & sync2_q);
    active  = pending & mask_q;

    // Lowest set index wins: scan downward so the last hit is the lowest.
    act_id = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) act_id = 3'(i);
    end

    pending_ext = '0;
    mask_ext    = '0;
    mode_ext    = '0;
    sync_ext    = '0;
    pending_ext[NUM_IRQ-1:0] = pending;
    mask_ext[NUM_IRQ-1:0]    = mask_q;
    mode_ext[NUM_IRQ-1:0]    = mode_q;
    sync_ext[NUM_IRQ-1:0]    = sync2_q;
  end

  always_comb begin
    latch_d   = latch_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    evcount_d = evcount_q;
    rdata_d   = '0;
    irq_d     = |active;

    // A rise beats a coincident clear; level-mode lines keep the latch at 0 so a
    // later switch to edge mode starts clean.
    if (wr_en && address == 3'd0) begin
      latch_d = mode_q & ((latch_q & ~wr_bits) | rise);
    end else begin
      latch_d = mode_q & (latch_q | rise);
    end

    if (wr_en && address == 3'd1) mask_d = wr_bits;
    if (wr_en && address == 3'd2) mode_d = wr_bits;

    // Clear wins over a coincident timer rise; count saturates.
    if (wr_en && address == 3'd5) begin
      evcount_d = '0;
    end else if (rise[0] && evcount_q != 16'hFFFF) begin
      evcount_d = evcount_q + 16'd1;
    end

    unique case (address)
      3'd0:    rdata_d = pending_ext;
      3'd1:    rdata_d = mask_ext;
      3'd2:    rdata_d = mode_ext;
      3'd3:    rdata_d = {|active, 12'b0, act_id};
      3'd4:    rdata_d = sync_ext;
      3'd5:    rdata_d = evcount_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_dly_q <= '0;
      latch_q    <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      evcount_q  <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= irq_in;
      sync2_q    <= sync1_q;
      sync_dly_q <= sync2_q;
      latch_q    <= latch_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      evcount_q  <= evcount_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/nios_sys_irq_ctrl.md
NIOS_SYS_IRQ_CTRL -- requirements
Module: nios_sys_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt source lines (legal range 1..8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  input  3  Avalon-MM register word select.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe.
REQ-007 SHALL have port writedata  input  16  write data.
REQ-008 SHALL have port irq_in  input  NUM_IRQ  asynchronous source lines (bit 0 = interval timer irq).
REQ-009 SHALL have port readdata  output  16  registered read data.
REQ-010 SHALL have port irq  output  1  registered aggregate interrupt to the CPU.

Function
REQ-011 SHALL pass irq_in through a 2-flop synchronizer; "sync" means the second-stage value.
REQ-012 SHALL hold a 1-flop delayed copy of sync; rise[i] = sync[i] & ~sync_d[i].
REQ-013 SHALL decode wr(a) = chipselect & ~write_n & (address == a).
REQ-014 SHALL implement register map: 0 PENDING, 1 MASK, 2 MODE, 3 ACTIVE, 4 RAW, 5 EVCOUNT; addresses 6-7 read 0 and ignore writes.
REQ-015 MODE[i]=1 SHALL select edge mode; MODE[i]=0 SHALL select level mode.
REQ-016 Edge mode: latch[i] SHALL set on rise[i] and clear on wr(0) with writedata[i]=1; simultaneous rise and clear -> stays set.
REQ-017 Level mode: PENDING[i] SHALL equal sync[i]; latch[i] SHALL be forced to 0 while in level mode.
REQ-018 PENDING[i] SHALL be latch[i] if MODE[i], else sync[i]; bits at or above NUM_IRQ read 0.
REQ-019 MASK SHALL be read/write on bits [NUM_IRQ-1:0]; 1 enables a line.
REQ-020 MODE SHALL be read/write on bits [NUM_IRQ-1:0].
REQ-021 active = PENDING & MASK; ACTIVE read SHALL return {valid, 12'b0, id[2:0]}, where valid = |active and id = lowest set index (0 when none).
REQ-022 RAW read SHALL return sync zero-extended.
REQ-023 EVCOUNT SHALL increment by 1 on each rise[0], independent of MASK/MODE.
REQ-024 EVCOUNT SHALL saturate at 16'hFFFF, never wrap.
REQ-025 Any wr(5) SHALL clear EVCOUNT to 0; a coincident rise[0] is dropped (clear wins).
REQ-026 irq SHALL be registered: irq <= |active, one cycle after active changes.
REQ-027 readdata SHALL register the read mux every cycle (no read strobe); 1-cycle latency, value reflects state before any same-cycle write.
REQ-028 Writes to MASK/MODE SHALL affect irq on the cycle after the write edge, with irq updating one cycle later.
REQ-029 Latency irq_in rise -> irq high (edge mode, unmasked) SHALL be exactly 4 clk edges (2 sync, 1 latch, 1 irq register).
REQ-030 Changing MODE from 1 to 0 SHALL discard latch[i]; changing 0 to 1 SHALL start with latch[i]=0.

Reset
REQ-031 Asserting reset SHALL immediately force all sync/delay flops, latch, MASK, MODE, EVCOUNT, readdata and irq to 0, regardless of clk.
REQ-032 During reset, writes SHALL be ignored; after deassertion, the first rise SHALL need a 0->1 transition seen entirely after reset.
REQ-033 Reset mid-operation SHALL drop pending edges and counts with no spurious irq on release.

Verification
REQ-034 Reset; read all six addresses -> readdata 0 each; irq 0.
REQ-035 MODE=1, MASK=1, pulse irq_in[0] for 1 cycle -> irq high exactly 4 edges later; PENDING=0x0001; write PENDING=0x0001 -> irq 0 two cycles later.
REQ-036 MODE=0, MASK=0x0C, hold irq_in[3] and irq_in[2] high -> ACTIVE=0x8002; drop irq_in[2] -> ACTIVE=0x8003; drop both -> ACTIVE=0x0000, irq 0.
REQ-037 Edge mode line 1: clear write and new rise in the same cycle -> PENDING bit 1 remains 1.
REQ-038 Apply 65540 rises on irq_in[0] -> EVCOUNT=0xFFFF; write address 5 -> EVCOUNT=0x0000.
REQ-039 Latch edge on line 4, assert reset asynchronously mid-cycle -> irq and PENDING 0 at once; release -> irq stays 0 while irq_in[4] is held high.
